// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared configuration for the register-file writeback arbiter.
//
// Contents:
//   DEF_XLEN, XREG_ADDRWIDTH    - register width and register address width
//   REG_COUNT                   - number of general registers (scoreboard width)
//   WB_FIFO_DEPTH               - depth of the long-latency result buffer
//   RST_ENABLE, WRITE_ENABLE    - active levels of reset and the write strobe
//   ZERO_32BIT                  - 32-bit all-zero constant
//   wb_src_e                    - which writer owns the register-file port
package regfile_wb_arbiter_pkg;

    localparam int DEF_XLEN       = 32;
    localparam int XREG_ADDRWIDTH = 5;
    localparam int REG_COUNT      = 32;
    localparam int WB_FIFO_DEPTH  = 2;

    localparam logic        RST_ENABLE   = 1'b1;
    localparam logic        WRITE_ENABLE = 1'b1;
    localparam logic [31:0] ZERO_32BIT   = 32'h0000_0000;

    // Owner of the register-file write port in the current cycle.
    typedef enum logic [1:0] {
        WB_SRC_NONE = 2'd0,
        WB_SRC_A    = 2'd1,
        WB_SRC_B    = 2'd2
    } wb_src_e;

endpackage

// File: rtl/regfile_wb_arbiter_wb_fifo.sv
// wb_fifo: small synchronous FIFO used to buffer long-latency results.
//
// Ports:
//   clk, rst      - clock, asynchronous active-high reset
//   push          - write push_data at the clock edge (ignored when full)
//   push_data     - entry to store
//   pop           - discard the head entry at the clock edge (ignored when empty)
//   head_data     - current head entry (valid when empty is low)
//   empty         - no entries stored
//   count         - number of stored entries, 0..DEPTH
//
// DEPTH must be a power of two so the pointers wrap by plain overflow.
module wb_fifo
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int WIDTH = 37,
    parameter int DEPTH = 2,
    localparam int PTRW = $clog2(DEPTH),
    localparam int CNTW = PTRW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             empty,
    output logic [CNTW-1:0]  count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTRW-1:0]  wr_ptr;
    logic [PTRW-1:0]  rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign full      = (count == CNTW'(DEPTH));
    assign empty     = (count == '0);
    assign do_push   = push & ~full;
    assign do_pop    = pop & ~empty;
    assign head_data = mem[rd_ptr];

    // Pointer and occupancy bookkeeping. A push and a pop in the same cycle
    // both advance their pointers and leave the count unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ENABLE) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTRW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTRW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNTW'(1);
                2'b01:   count <= count - CNTW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage array. Contents need no reset: the pointers alone decide which
    // slots hold live entries.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register-file write port between the
// in-order pipeline writeback (port A, absolute priority, no backpressure)
// and a long-latency unit (port B, valid/ready, buffered in a FIFO that
// drains only when A is idle). A scoreboard of outstanding long-latency
// destinations feeds the decode-stage busy checks.
//
// Ports:
//   clk, rst                     - clock, asynchronous active-high reset
//   i_a_valid/addr/data          - pipeline writeback request
//   i_b_valid/addr/data          - long-latency result, o_b_ready handshake
//   o_b_ready                    - result buffer can accept a B result
//   i_issue_valid/addr           - decode issues to the long-latency unit
//   i_rs1_addr/rs2_addr/rd_addr  - decode operands for the busy checks
//   o_rs1_busy/rs2_busy/rd_busy  - operand has a pending long-latency write
//   o_write_flag/addr/data       - register-file write port
//   o_pending                    - scoreboard, bit n = xn pending
//   o_err                        - sticky protocol-violation flag
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int XLEN       = DEF_XLEN,
    parameter int ADDRW      = XREG_ADDRWIDTH,
    parameter int FIFO_DEPTH = WB_FIFO_DEPTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_a_valid,
    input  logic [ADDRW-1:0]     i_a_addr,
    input  logic [XLEN-1:0]      i_a_data,
    input  logic                 i_b_valid,
    input  logic [ADDRW-1:0]     i_b_addr,
    input  logic [XLEN-1:0]      i_b_data,
    output logic                 o_b_ready,
    input  logic                 i_issue_valid,
    input  logic [ADDRW-1:0]     i_issue_addr,
    input  logic [ADDRW-1:0]     i_rs1_addr,
    input  logic [ADDRW-1:0]     i_rs2_addr,
    input  logic [ADDRW-1:0]     i_rd_addr,
    output logic                 o_rs1_busy,
    output logic                 o_rs2_busy,
    output logic                 o_rd_busy,
    output logic                 o_write_flag,
    output logic [ADDRW-1:0]     o_write_addr,
    output logic [XLEN-1:0]      o_write_data,
    output logic [REG_COUNT-1:0] o_pending,
    output logic                 o_err
);

    localparam int ENTRYW = ADDRW + XLEN;
    localparam int CNTW   = $clog2(FIFO_DEPTH) + 1;

    logic [ENTRYW-1:0]    fifo_head;
    logic                 fifo_empty;
    logic [CNTW-1:0]      fifo_count;
    logic                 fifo_push;
    logic                 fifo_pop;
    logic [ADDRW-1:0]     head_addr;
    logic [XLEN-1:0]      head_data;

    logic                 b_xfer;
    wb_src_e              wb_src;
    logic [REG_COUNT-1:0] pending;
    logic [REG_COUNT-1:0] pending_nxt;
    logic                 err_now;

    assign head_addr = fifo_head[XLEN +: ADDRW];
    assign head_data = fifo_head[XLEN-1:0];

    // Ready ignores a same-cycle drain on purpose, keeping it off the A path.
    assign o_b_ready = ~rst & (fifo_count < CNTW'(FIFO_DEPTH));
    assign b_xfer    = i_b_valid & o_b_ready;
    // Results for x0 complete the handshake but are never stored.
    assign fifo_push = b_xfer & (i_b_addr != '0);
    assign fifo_pop  = (wb_src == WB_SRC_B);

    wb_fifo #(
        .WIDTH (ENTRYW),
        .DEPTH (FIFO_DEPTH)
    ) u_b_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data ({i_b_addr, i_b_data}),
        .pop       (fifo_pop),
        .head_data (fifo_head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Write-port arbitration: the pipeline always wins; buffered results
    // fill otherwise idle cycles. Everything is held quiet during reset.
    always_comb begin
        wb_src       = WB_SRC_NONE;
        o_write_flag = 1'b0;
        o_write_addr = '0;
        o_write_data = '0;
        if (rst != RST_ENABLE) begin
            if (i_a_valid) begin
                wb_src = WB_SRC_A;
            end else if (!fifo_empty) begin
                wb_src = WB_SRC_B;
            end
        end
        case (wb_src)
            WB_SRC_A: begin
                o_write_flag = WRITE_ENABLE;
                o_write_addr = i_a_addr;
                o_write_data = i_a_data;
            end
            WB_SRC_B: begin
                o_write_flag = WRITE_ENABLE;
                o_write_addr = head_addr;
                o_write_data = head_data;
            end
            default: ;
        endcase
    end

    // Scoreboard next state: a drain clears its destination, then a new
    // issue sets its own. Applying the set last lets an issue win over a
    // drain to the same register. x0 is never tracked.
    always_comb begin
        pending_nxt = pending;
        if (fifo_pop && (head_addr != '0)) begin
            pending_nxt[head_addr] = 1'b0;
        end
        if (i_issue_valid && (i_issue_addr != '0)) begin
            pending_nxt[i_issue_addr] = 1'b1;
        end
        pending_nxt[0] = 1'b0;
    end

    // Protocol violations: the pipeline overwriting a register that still
    // awaits a long-latency result, or a result arriving for a register that
    // was never issued.
    always_comb begin
        err_now = 1'b0;
        if (i_a_valid && (i_a_addr != '0) && pending[i_a_addr]) begin
            err_now = 1'b1;
        end
        if (b_xfer && (i_b_addr != '0) && !pending[i_b_addr]) begin
            err_now = 1'b1;
        end
    end

    // Scoreboard and sticky error registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ENABLE) begin
            pending <= ZERO_32BIT;
            o_err   <= 1'b0;
        end else begin
            pending <= pending_nxt;
            if (err_now) begin
                o_err <= 1'b1;
            end
        end
    end

    assign o_pending  = pending;
    assign o_rs1_busy = pending[i_rs1_addr] & (i_rs1_addr != '0);
    assign o_rs2_busy = pending[i_rs2_addr] & (i_rs2_addr != '0);
    assign o_rd_busy  = pending[i_rd_addr] & (i_rd_addr != '0);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Testbench for regfile_wb_arbiter: directed scenarios with hand-computed
// literal expectations, plus a queue-based reference model compared against
// the DUT outputs on every falling clock edge.
module tb_regfile_wb_arbiter;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_a_valid = 1'b0;
    logic [4:0]  i_a_addr = '0;
    logic [31:0] i_a_data = '0;
    logic        i_b_valid = 1'b0;
    logic [4:0]  i_b_addr = '0;
    logic [31:0] i_b_data = '0;
    logic        o_b_ready;
    logic        i_issue_valid = 1'b0;
    logic [4:0]  i_issue_addr = '0;
    logic [4:0]  i_rs1_addr = '0;
    logic [4:0]  i_rs2_addr = '0;
    logic [4:0]  i_rd_addr = '0;
    logic        o_rs1_busy;
    logic        o_rs2_busy;
    logic        o_rd_busy;
    logic        o_write_flag;
    logic [4:0]  o_write_addr;
    logic [31:0] o_write_data;
    logic [31:0] o_pending;
    logic        o_err;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter dut (
        .clk           (clk),
        .rst           (rst),
        .i_a_valid     (i_a_valid),
        .i_a_addr      (i_a_addr),
        .i_a_data      (i_a_data),
        .i_b_valid     (i_b_valid),
        .i_b_addr      (i_b_addr),
        .i_b_data      (i_b_data),
        .o_b_ready     (o_b_ready),
        .i_issue_valid (i_issue_valid),
        .i_issue_addr  (i_issue_addr),
        .i_rs1_addr    (i_rs1_addr),
        .i_rs2_addr    (i_rs2_addr),
        .i_rd_addr     (i_rd_addr),
        .o_rs1_busy    (o_rs1_busy),
        .o_rs2_busy    (o_rs2_busy),
        .o_rd_busy     (o_rd_busy),
        .o_write_flag  (o_write_flag),
        .o_write_addr  (o_write_addr),
        .o_write_data  (o_write_data),
        .o_pending     (o_pending),
        .o_err         (o_err)
    );

    task automatic checkOutput(input string name, input logic [63:0] act,
                               input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } entry_t;

    entry_t      m_q[$];
    bit   [31:0] m_pend;
    bit          m_err;

    task automatic modelClear();
        m_q.delete();
        m_pend = '0;
        m_err  = 1'b0;
    endtask

    task automatic modelCheck();
        logic        e_ready, e_flag;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
        if (rst) modelClear();
        e_ready = !rst && (m_q.size() < DEPTH);
        e_flag  = 1'b0;
        e_addr  = '0;
        e_data  = '0;
        if (!rst) begin
            if (i_a_valid) begin
                e_flag = 1'b1; e_addr = i_a_addr; e_data = i_a_data;
            end else if (m_q.size() > 0) begin
                e_flag = 1'b1; e_addr = m_q[0].addr; e_data = m_q[0].data;
            end
        end
        checkOutput("model_b_ready", o_b_ready, e_ready);
        checkOutput("model_write_flag", o_write_flag, e_flag);
        checkOutput("model_write_addr", o_write_addr, e_addr);
        checkOutput("model_write_data", o_write_data, e_data);
        checkOutput("model_pending", o_pending, m_pend);
        checkOutput("model_err", o_err, m_err);
        checkOutput("model_rs1_busy", o_rs1_busy, m_pend[i_rs1_addr] && i_rs1_addr != 0);
        checkOutput("model_rs2_busy", o_rs2_busy, m_pend[i_rs2_addr] && i_rs2_addr != 0);
        checkOutput("model_rd_busy", o_rd_busy, m_pend[i_rd_addr] && i_rd_addr != 0);
    endtask

    task automatic modelUpdate();
        bit     xfer;
        entry_t e;
        if (rst) begin
            modelClear();
            return;
        end
        xfer = i_b_valid && (m_q.size() < DEPTH);
        if (i_a_valid && i_a_addr != 0 && m_pend[i_a_addr]) m_err = 1'b1;
        if (xfer && i_b_addr != 0 && !m_pend[i_b_addr]) m_err = 1'b1;
        if (!i_a_valid && m_q.size() > 0) begin
            e = m_q.pop_front();
            m_pend[e.addr] = 1'b0;
        end
        if (xfer && i_b_addr != 0) begin
            e.addr = i_b_addr;
            e.data = i_b_data;
            m_q.push_back(e);
        end
        if (i_issue_valid && i_issue_addr != 0) m_pend[i_issue_addr] = 1'b1;
        m_pend[0] = 1'b0;
    endtask

    // Compare process: inputs change just after the rising edge, so the
    // falling edge sees settled outputs; the model then advances on the edge.
    initial begin
        modelClear();
        forever begin
            @(negedge clk);
            modelCheck();
            @(posedge clk);
            modelUpdate();
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic applyStimulus(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                                 input logic bv, input logic [4:0] ba, input logic [31:0] bd,
                                 input logic iv, input logic [4:0] ia);
        i_a_valid = av;  i_a_addr = aa;  i_a_data = ad;
        i_b_valid = bv;  i_b_addr = ba;  i_b_data = bd;
        i_issue_valid = iv;  i_issue_addr = ia;
    endtask

    task automatic idle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        #2;
        checkOutput("reset_b_ready", o_b_ready, 0);
        checkOutput("reset_write_flag", o_write_flag, 0);
        checkOutput("reset_pending", o_pending, 0);
        checkOutput("reset_err", o_err, 0);
        nextCycle();
        nextCycle();
        rst = 1'b0;
        #1;
        checkOutput("post_reset_b_ready", o_b_ready, 1);

        // B-only path through x5
        i_rs1_addr = 5'd5;
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 5);
        #1 checkOutput("t1_busy_before_issue", o_rs1_busy, 0);
        nextCycle();
        applyStimulus(0, 0, 0, 1, 5, 32'hDEADBEEF, 0, 0);
        #1 checkOutput("t1_busy_pending", o_rs1_busy, 1);
        checkOutput("t1_no_bypass", o_write_flag, 0);
        nextCycle();
        idle();
        #1 checkOutput("t1_drain_flag", o_write_flag, 1);
        checkOutput("t1_drain_addr", o_write_addr, 5);
        checkOutput("t1_drain_data", o_write_data, 32'hDEADBEEF);
        nextCycle();
        checkOutput("t1_busy_after", o_rs1_busy, 0);
        checkOutput("t1_pending_after", o_pending, 0);
        i_rs1_addr = 5'd0;

        // A priority over a buffered x7
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 7);
        nextCycle();
        applyStimulus(0, 0, 0, 1, 7, 32'h11, 0, 0);
        nextCycle();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 3, 32'h22, 0, 0, 0, 0, 0);
            #1 checkOutput("t2_a_addr", o_write_addr, 3);
            checkOutput("t2_a_data", o_write_data, 32'h22);
            nextCycle();
        end
        idle();
        #1 checkOutput("t2_b_addr", o_write_addr, 7);
        checkOutput("t2_b_data", o_write_data, 32'h11);
        checkOutput("t2_err", o_err, 0);
        nextCycle();
        nextCycle();

        // FIFO full while A is busy
        applyStimulus(1, 1, 32'hAA, 0, 0, 0, 1, 8);   nextCycle();
        applyStimulus(1, 1, 32'hAA, 0, 0, 0, 1, 9);   nextCycle();
        applyStimulus(1, 1, 32'hAA, 0, 0, 0, 1, 10);  nextCycle();
        applyStimulus(1, 1, 32'hAA, 1, 8, 32'h80, 0, 0);  nextCycle();
        applyStimulus(1, 1, 32'hAA, 1, 9, 32'h90, 0, 0);  nextCycle();
        applyStimulus(1, 1, 32'hAA, 1, 10, 32'hA0, 0, 0);
        #1 checkOutput("t3_full_ready", o_b_ready, 0);
        nextCycle();
        #1 checkOutput("t3_full_ready_hold", o_b_ready, 0);
        checkOutput("t3_a_owns_port", o_write_addr, 1);
        nextCycle();
        applyStimulus(0, 0, 0, 1, 10, 32'hA0, 0, 0);
        #1 checkOutput("t3_conservative_ready", o_b_ready, 0);
        checkOutput("t3_drain_x8", o_write_addr, 8);
        nextCycle();
        #1 checkOutput("t3_ready_again", o_b_ready, 1);
        checkOutput("t3_drain_x9", o_write_addr, 9);
        nextCycle();
        idle();
        #1 checkOutput("t3_drain_x10_addr", o_write_addr, 10);
        checkOutput("t3_drain_x10_data", o_write_data, 32'hA0);
        nextCycle();
        checkOutput("t3_pending_clear", o_pending, 0);
        nextCycle();

        // Issue x4 on the same cycle as x4 drains
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 4);  nextCycle();
        applyStimulus(0, 0, 0, 1, 4, 32'h44, 0, 0);  nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 4);
        #1 checkOutput("t4_drain_x4", o_write_addr, 4);
        nextCycle();
        idle();
        #1 checkOutput("t4_set_wins", o_pending, 32'h0000_0010);
        nextCycle();

        // WAW violation on x6
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 6);  nextCycle();
        applyStimulus(1, 6, 32'h66, 0, 0, 0, 0, 0);
        #1 checkOutput("t5_err_before", o_err, 0);
        nextCycle();
        idle();
        #1 checkOutput("t5_err_waw", o_err, 1);
        nextCycle();
        nextCycle();
        checkOutput("t5_err_sticky", o_err, 1);
        rst = 1'b1;
        #1 checkOutput("t5_err_reset", o_err, 0);
        nextCycle();
        rst = 1'b0;

        // Unissued result to x12
        applyStimulus(0, 0, 0, 1, 12, 32'hCC, 0, 0);
        nextCycle();
        idle();
        #1 checkOutput("t5_err_unissued", o_err, 1);
        checkOutput("t5_x12_drain", o_write_addr, 12);
        nextCycle();

        // x0 handling
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);  nextCycle();
        idle();
        #1 checkOutput("t5_x0_issue", o_pending, 0);
        applyStimulus(0, 0, 0, 1, 0, 32'h55, 0, 0);
        #1 checkOutput("t5_x0_ready", o_b_ready, 1);
        nextCycle();
        idle();
        #1 checkOutput("t5_x0_no_write", o_write_flag, 0);
        nextCycle();

        // Asynchronous reset with two buffered entries
        rst = 1'b1;
        nextCycle();
        rst = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 13);  nextCycle();
        applyStimulus(1, 2, 32'hBB, 0, 0, 0, 1, 14);  nextCycle();
        applyStimulus(1, 2, 32'hBB, 1, 13, 32'hD0, 0, 0);  nextCycle();
        applyStimulus(1, 2, 32'hBB, 1, 14, 32'hE0, 0, 0);  nextCycle();
        idle();
        #1 checkOutput("t6_head_before", o_write_addr, 13);
        checkOutput("t6_pending_before", o_pending, 32'h0000_6000);
        #1 rst = 1'b1;
        #1 checkOutput("t6_async_flag", o_write_flag, 0);
        checkOutput("t6_async_pending", o_pending, 0);
        checkOutput("t6_async_ready", o_b_ready, 0);
        nextCycle();
        rst = 1'b0;
        #1 checkOutput("t6_fifo_empty", o_write_flag, 0);
        checkOutput("t6_ready_after", o_b_ready, 1);
        nextCycle();
        nextCycle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
